// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with a 2**FIFO_AW byte FIFO, back-to-back frames.
// Define UART_TX_FIFO_PARITY_EN to add an even-parity bit (8E1, 11-bit frame).
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_AW      = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_wr_en,
   input  logic [7:0]         i_wr_byte,
   output logic               o_full,
   output logic               o_empty,
   output logic [FIFO_AW:0]   o_level,
   output logic               o_overflow,
   output logic               o_tx,
   output logic               o_busy,
   output logic               o_tx_done
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_FIFO_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd4
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [BW-1:0]      baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]         mem_q [DEPTH];
   logic [7:0]         mem_d [DEPTH];

   logic               full, empty, push, pop, baud_last;
   logic [7:0]         head;
   logic [2:0]         nxt_bit;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign push  = i_wr_en && !full;
   assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign baud_last = (baud_q == BAUD_MAX);
   assign nxt_bit = bit_q + 3'd1;

   always_comb begin
      state_d  = state_q;
      baud_d   = '0;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ovf_d    = i_wr_en && full;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      pop      = 1'b0;

      if (state_q != S_IDLE && !baud_last)
         baud_d = baud_q + 1'b1;

      unique case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (baud_last) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_FIFO_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = ^shift_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = nxt_bit;
                  tx_d  = shift_q[nxt_bit];
               end
            end
         end
`ifdef UART_TX_FIFO_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               done_d = 1'b1;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  busy_d  = 1'b0;
                  tx_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      if (push) begin
         mem_d[wr_ptr_q[FIFO_AW-1:0]] = i_wr_byte;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

   assign o_full     = full;
   assign o_empty    = empty;
   assign o_level    = wr_ptr_q - rd_ptr_q;
   assign o_overflow = ovf_q;
   assign o_tx       = tx_q;
   assign o_busy     = busy_q;
   assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a line-sampling receiver plus a byte-queue
// model predict FIFO level, flags, busy/done timing and every decoded frame.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
`ifdef UART_TX_FIFO_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRM = NBITS * CPB;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_byte = 8'h00;
   logic        full, empty, ovf, tx, busy, done;
   logic [AW:0] level;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_byte(wr_byte),
      .o_full(full), .o_empty(empty), .o_level(level), .o_overflow(ovf),
      .o_tx(tx), .o_busy(busy), .o_tx_done(done)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   int  acc, started, mcnt, cyc;
   int  busy_cnt, done_cnt, ovf_cnt, frames, peak, first_busy, last_busy;
   bit  in_frame, fin_prev, ovf_exp;
   logic samp [0:FRM-1];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic finish_frame();
      logic [7:0] rx;
      logic [7:0] eb;
      logic mid;
      bit glitch;
      rx = '0;
      glitch = 0;
      for (int b = 0; b < NBITS; b++) begin
         mid = samp[b*CPB+2];
         for (int k = 0; k < CPB; k++)
            if (samp[b*CPB+k] !== mid) glitch = 1;
         if (b >= 1 && b <= 8) rx[b-1] = mid;
      end
      check("start_bit", samp[2], 1'b0);
      check("stop_bit", samp[(NBITS-1)*CPB+2], 1'b1);
      check("bit_hold", glitch, 1'b0);
      if (exp_q.size() == 0) begin
         check("spurious_frame", 1, 0);
      end else begin
         eb = exp_q.pop_front();
         check("frame_data", rx, eb);
`ifdef UART_TX_FIFO_PARITY_EN
         check("parity_bit", samp[9*CPB+2], ^eb);
`endif
      end
      frames++;
   endtask

   task automatic sample();
      bit done_exp, busy_exp;
      int lv;
      cyc++;
      done_exp = fin_prev;
      fin_prev = 0;
      if (!in_frame && tx === 1'b0) begin
         in_frame = 1;
         mcnt = 0;
         started++;
      end
      busy_exp = in_frame;
      if (in_frame) begin
         samp[mcnt] = tx;
         mcnt++;
         if (mcnt == FRM) begin
            finish_frame();
            in_frame = 0;
            fin_prev = 1;
         end
      end
      lv = acc - started;
      check("level", level, lv);
      check("full", full, lv == DEPTH);
      check("empty", empty, lv == 0);
      check("overflow", ovf, ovf_exp);
      check("busy", busy, busy_exp);
      check("tx_done", done, done_exp);
      if (busy === 1'b1) begin
         busy_cnt++;
         if (first_busy < 0) first_busy = cyc;
         last_busy = cyc;
      end
      if (done === 1'b1) done_cnt++;
      if (ovf === 1'b1) ovf_cnt++;
      if (int'(level) > peak) peak = int'(level);
   endtask

   task automatic step(input bit wr, input logic [7:0] b);
      @(negedge clk);
      sample();
      wr_en = wr;
      wr_byte = b;
      ovf_exp = 0;
      if (wr) begin
         if (acc - started == DEPTH) begin
            ovf_exp = 1;
         end else begin
            exp_q.push_back(b);
            acc++;
         end
      end
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_frame || fin_prev) && n < max) begin
         step(1'b0, 8'h00);
         n++;
      end
      check("drain_in_time", n < max, 1);
   endtask

   task automatic clr();
      busy_cnt = 0;
      done_cnt = 0;
      ovf_cnt = 0;
      frames = 0;
      peak = 0;
      first_busy = -1;
      last_busy = -1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      wr_en = 1'b0;
      #1;
      check("rst_tx", tx, 1'b1);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_level", level, 0);
      check("rst_overflow", ovf, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_tx_done", done, 1'b0);
      exp_q.delete();
      acc = 0;
      started = 0;
      in_frame = 0;
      fin_prev = 0;
      ovf_exp = 0;
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_done", done, 1'b0);
         check("rst_hold_tx", tx, 1'b1);
      end
      rst = 1'b0;
   endtask

   initial begin
      int n;
      cyc = 0;
      clr();
      apply_reset();

      // single frame, 0xAB
      clr();
      step(1'b1, 8'hAB);
      drain(200);
      check("t1_frames", frames, 1);
      check("t1_done", done_cnt, 1);
      check("t1_busy_clks", busy_cnt, FRM);

      // three consecutive writes, frames must abut
      clr();
      step(1'b1, 8'h00);
      step(1'b1, 8'hFF);
      step(1'b1, 8'h55);
      drain(400);
      check("t2_frames", frames, 3);
      check("t2_done", done_cnt, 3);
      check("t2_busy_clks", busy_cnt, 3 * FRM);
      check("t2_busy_span", last_busy - first_busy + 1, 3 * FRM);

      // overrun the FIFO
      clr();
      for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h10 + i));
      drain(2000);
      check("t3_peak", peak, DEPTH);
      check("t3_ovf_pulses", ovf_cnt, 1);
      check("t3_frames", frames, 17);

      // reset during data bit 3
      clr();
      step(1'b1, 8'h96);
      n = 0;
      while (!(in_frame && mcnt == 4 * CPB + 1) && n < 100) begin
         step(1'b0, 8'h00);
         n++;
      end
      check("t4_reach_bit3", n < 100, 1);
      apply_reset();
      step(1'b0, 8'h00);
      clr();
      step(1'b1, 8'h3C);
      drain(200);
      check("t4_frames", frames, 1);
      check("t4_done", done_cnt, 1);

      // parity examples (frame length follows build)
      clr();
      step(1'b1, 8'h07);
      drain(200);
      check("t5_busy_clks", busy_cnt, FRM);
      step(1'b1, 8'h03);
      drain(200);
      check("t5_frames", frames, 2);

      // random traffic with bursts
      clr();
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
      drain(3000);
      check("rand_overflow_seen", ovf_cnt > 0, 1);
      check("rand_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
